// File: rtl/fft_axis_out_ctrl.sv
// Readout sequencer: FFT result memory -> word buffer -> beat FIFO -> one AXI-Stream packet per frame.
// Latency start_i -> first tvalid 4 cycles; reads are throttled so FIFO + buffer never overflow under backpressure.
module fft_axis_out_ctrl #(
    parameter int VLW_WDT           = 64,
    parameter int M_TDATA_WDT       = 32,
    parameter int C_FFT_SIZE_LOG2   = 12,
    parameter int M_FIFO_SIZE       = 16,
    parameter int OUTPUT_MEM_OFFSET = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       mem_rd_en_o,
    output logic [C_FFT_SIZE_LOG2-1:0] mem_rd_addr_o,
    input  logic [VLW_WDT-1:0]         mem_rd_data_i,
    output logic [M_TDATA_WDT-1:0]     m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast
);
    localparam int BEATS        = VLW_WDT / M_TDATA_WDT;
    localparam int FFT_MEM_SIZE = 2 ** C_FFT_SIZE_LOG2;
    localparam int M_PACKET_CNT = FFT_MEM_SIZE * BEATS;
    localparam int PW           = $clog2(M_FIFO_SIZE);
    localparam int CW           = PW + 1;
    localparam int BW           = $clog2(BEATS + 1);
    localparam int KW           = $clog2(M_PACKET_CNT);

    localparam logic [C_FFT_SIZE_LOG2-1:0] ADDR_OFFS =
        C_FFT_SIZE_LOG2'(OUTPUT_MEM_OFFSET % FFT_MEM_SIZE);
    localparam logic [CW:0]   OCC_MAX   = (CW+1)'(M_FIFO_SIZE - BEATS);
    localparam logic [KW-1:0] LAST_BEAT = KW'(M_PACKET_CNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                     r_state, w_state_nxt;
    logic [C_FFT_SIZE_LOG2-1:0] r_word_cnt;
    logic                       r_rd_pend;
    logic [VLW_WDT-1:0]         r_buf;
    logic [BW-1:0]              r_buf_cnt;
    logic [KW-1:0]              r_beat_cnt;
    logic [M_TDATA_WDT:0]       r_fifo_mem [M_FIFO_SIZE];
    logic [PW-1:0]              r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]              r_fifo_cnt;
    logic                       r_done;

    logic        w_fifo_full, w_fifo_empty, w_push, w_pop, w_buf_free, w_rd_issue;
    logic        w_start, w_last_word, w_last_pop;
    logic [CW:0] w_occ;

    assign w_fifo_full  = (r_fifo_cnt == CW'(M_FIFO_SIZE));
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_push       = (r_buf_cnt != '0) && !w_fifo_full;
    assign w_pop        = !w_fifo_empty && m_axis_tready;
    assign w_last_pop   = w_pop && m_axis_tlast;
    assign w_start      = (r_state == S_IDLE) && start_i;
    assign w_last_word  = (r_word_cnt == '1);

    // A new word may land only when the buffer is empty by capture time and the FIFO has room for all of it.
    assign w_occ      = {1'b0, r_fifo_cnt} + (CW+1)'(r_buf_cnt);
    assign w_buf_free = (r_buf_cnt == '0) || ((r_buf_cnt == BW'(1)) && w_push);
    assign w_rd_issue = (r_state == S_READ) && !r_rd_pend && w_buf_free && (w_occ <= OCC_MAX);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_READ;
            S_READ:  if (w_rd_issue && w_last_word) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_pop) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_word_cnt <= '0;
            r_rd_pend  <= 1'b0;
            r_buf      <= '0;
            r_buf_cnt  <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= (r_state == S_DRAIN) && w_last_pop;
            r_rd_pend <= w_rd_issue;

            if (w_start)
                r_word_cnt <= '0;
            else if (w_rd_issue)
                r_word_cnt <= r_word_cnt + C_FFT_SIZE_LOG2'(1);

            if (r_rd_pend) begin
                r_buf     <= mem_rd_data_i;
                r_buf_cnt <= BW'(BEATS);
            end else if (w_push) begin
                r_buf     <= r_buf << M_TDATA_WDT;
                r_buf_cnt <= r_buf_cnt - BW'(1);
            end

            if (w_start)
                r_beat_cnt <= '0;
            else if (w_push)
                r_beat_cnt <= r_beat_cnt + KW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M_FIFO_SIZE; i++) r_fifo_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= {(r_beat_cnt == LAST_BEAT), r_buf[VLW_WDT-1 -: M_TDATA_WDT]};
                r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = r_done;
    assign mem_rd_en_o   = w_rd_issue;
    assign mem_rd_addr_o = w_rd_issue ? (ADDR_OFFS + r_word_cnt) : '0;
    assign m_axis_tvalid = !w_fifo_empty;
    assign {m_axis_tlast, m_axis_tdata} = r_fifo_mem[r_rd_ptr];

endmodule
